// File: rtl/timer_sched_pkg.sv
// Shared types and helpers for the interval timer scheduler.
// State encoding, load width and the period computation with zero clamp.
package timer_sched_pkg;

  localparam int LOAD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A zero load would never expire, so it collapses to a single tick.
  function automatic logic [31:0] period(
    input logic [LOAD_W-1:0] load,
    input int unsigned       shift
  );
    logic [31:0] wide;
    wide = {{(32-LOAD_W){1'b0}}, load};
    if (load == '0) return 32'd1;
    return wide << shift;
  endfunction

endpackage

// File: rtl/timer_sched_if.sv
// Request/grant bundle between the requesting FSMs and the timer scheduler.
// master drives requests and tick, slave returns grant/done/status.
interface timer_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 9
);
  import timer_sched_pkg::*;

  logic                      tick;
  logic [NUM_REQ-1:0]        req;
  logic [LOAD_W*NUM_REQ-1:0] load_val;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;
  logic [CNT_W-1:0]          cur_count;

  modport master (
    output tick, req, load_val,
    input  grant, done, busy, cur_count
  );

  modport slave (
    input  tick, req, load_val,
    output grant, done, busy, cur_count
  );

endinterface

// File: rtl/timer_sched_rr_arbiter.sv
// Combinational requester picker: round-robin from ptr, wrapping at NUM_REQ.
// With ARB_FIXED_PRIO_EN defined it is a lowest-index priority encoder.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic found;

`ifdef ARB_FIXED_PRIO_EN
  // First set request from index 0 upward wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end
`else
  int unsigned pos;

  // Walk from ptr upward, wrapping, and take the first set request.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = 32'(ptr) + 32'(i);
      if (pos >= 32'(NUM_REQ)) pos = pos - 32'(NUM_REQ);
      if (!found && req[IDX_W'(pos)]) begin
        found            = 1'b1;
        gnt[IDX_W'(pos)] = 1'b1;
        idx              = IDX_W'(pos);
      end
    end
  end
`endif

endmodule

// File: rtl/timer_sched.sv
// One shared down-counting interval timer arbitrated among NUM_REQ requesters.
// Build option ARB_FIXED_PRIO_EN: fixed lowest-index priority, no rr pointer.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SCALE_SHIFT = 5,
  parameter int CNT_W       = 9
) (
  input logic         clk,
  input logic         rst_n,
  timer_sched_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (CNT_W < LOAD_W + SCALE_SHIFT) begin : g_cnt_chk
    $error("timer_sched: CNT_W narrower than LOAD_W+SCALE_SHIFT");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_req_chk
    $error("timer_sched: NUM_REQ must be 2..8");
  end

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   owner_nxt;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] done_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [LOAD_W-1:0]  load_sel;
  logic               any_req;
  logic               own_req;
  logic               expire;

  assign any_req  = |bus.req;
  assign own_req  = bus.req[owner];
  assign expire   = bus.tick && (cnt == CNT_W'(1));
  assign load_sel = bus.load_val[arb_idx*LOAD_W +: LOAD_W];

`ifdef ARB_FIXED_PRIO_EN
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (bus.req),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );
`else
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] owner_inc;

  assign owner_inc = (owner == IDX_W'(NUM_REQ-1)) ? '0
                   : owner + IDX_W'(1);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (bus.req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Pointer moves past the owner on both expiry and cancel.
  always_comb begin
    ptr_nxt = ptr;
    if ((state == ST_COUNT && !own_req) || state == ST_DONE)
      ptr_nxt = owner_inc;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; cancel wins over expiry.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_COUNT;
      ST_COUNT: begin
        if (!own_req)    state_nxt = ST_IDLE;
        else if (expire) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and owner.
  always_comb begin
    grant_nxt = grant_q;
    done_nxt  = '0;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          owner_nxt = arb_idx;
          grant_nxt = arb_gnt;
          cnt_nxt   = CNT_W'(period(load_sel, SCALE_SHIFT));
        end
      end
      ST_COUNT: begin
        if (!own_req) begin
          grant_nxt = '0;
          cnt_nxt   = '0;
        end else if (bus.tick && !expire) begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        done_nxt  = grant_q;
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
      default: begin
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output, counter and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      done_q  <= '0;
      cnt     <= '0;
      owner   <= '0;
    end else begin
      grant_q <= grant_nxt;
      done_q  <= done_nxt;
      cnt     <= cnt_nxt;
      owner   <= owner_nxt;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.cur_count = cnt;
  assign bus.busy      = (state != ST_IDLE);

endmodule
